// File: rtl/sum_latch_uart_n.sv
// sum_latch_uart_n: latches up to NUM_OPS operands from a shared bus on
// active-low strobes, keeps a registered running sum and sends it LSB-byte
// first over an 8N1 UART whenever the sum has been reloaded since the last frame.
module sum_latch_uart_n #(
   parameter int unsigned DATA_W       = 3,
   parameter int unsigned NUM_OPS      = 4,
   parameter int unsigned CLKS_PER_BIT = 16,
   localparam int unsigned SUM_W       = DATA_W + $unsigned($clog2(NUM_OPS)),
   localparam int unsigned NBYTES      = (SUM_W + 7) / 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_OPS-1:0]  save_n,
   input  logic [DATA_W-1:0]   data_input,
   input  logic                clear,
   input  logic                uart_tx_en,
   output logic                uart_txd,
   output logic                uart_tx_busy,
   output logic [SUM_W-1:0]    sum_out
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned SNAP_W = NBYTES * 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   logic [NUM_OPS-1:0] sync1, sync2, hist, fall_q;
   logic [DATA_W-1:0]  op [NUM_OPS];
   logic               load_q;
   logic [SUM_W-1:0]   sum_c;
   logic               dirty;
   tx_state_t          state;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         bit_idx;
   logic [IDX_W-1:0]   byte_idx;
   logic [SNAP_W-1:0]  shreg;
   logic               bit_last;
   logic               frame_start;

   // Two-flop synchroniser, history flop and registered falling-edge pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= '1;
         sync2  <= '1;
         hist   <= '1;
         fall_q <= '0;
      end else begin
         sync1  <= save_n;
         sync2  <= sync1;
         hist   <= sync2;
         fall_q <= hist & ~sync2;
      end
   end

   // Operand registers; clear beats any save landing in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OPS; i++) op[i] <= '0;
         load_q <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < NUM_OPS; i++) op[i] <= '0;
         load_q <= 1'b1;
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (fall_q[i]) op[i] <= data_input;
         end
         load_q <= |fall_q;
      end
   end

   // Zero-extended sum of all operands
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NUM_OPS; i++) sum_c = sum_c + SUM_W'(op[i]);
   end

   assign bit_last    = (cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign frame_start = (state == IDLE) && uart_tx_en && dirty;

   // Sum register, dirty flag and UART transmit state machine
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_out      <= '0;
         dirty        <= 1'b0;
         state        <= IDLE;
         uart_txd     <= 1'b1;
         uart_tx_busy <= 1'b0;
         cnt          <= '0;
         bit_idx      <= '0;
         byte_idx     <= '0;
         shreg        <= '0;
      end else begin
         if (load_q) sum_out <= sum_c;

         // a reload in the same cycle as a frame start keeps the flag set
         if (load_q)           dirty <= 1'b1;
         else if (frame_start) dirty <= 1'b0;

         case (state)
            IDLE: begin
               if (frame_start) begin
                  shreg        <= SNAP_W'(sum_out);
                  byte_idx     <= '0;
                  cnt          <= '0;
                  uart_txd     <= 1'b0;
                  uart_tx_busy <= 1'b1;
                  state        <= START;
               end
            end
            START: begin
               if (bit_last) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  uart_txd <= shreg[0];
                  state    <= DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_last) begin
                  cnt   <= '0;
                  shreg <= shreg >> 1;
                  if (bit_idx == 3'd7) begin
                     uart_txd <= 1'b1;
                     state    <= STOP;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     uart_txd <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_last) begin
                  cnt <= '0;
                  if (byte_idx == IDX_W'(NBYTES - 1)) begin
                     uart_tx_busy <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + IDX_W'(1);
                     uart_txd <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_latch_uart_n.sv
// Bench for sum_latch_uart_n: a 3-bit/4-operand instance (single-byte frames)
// and an 8-bit/4-operand instance (two-byte frames), both at 4 clocks per bit.
module tb_sum_latch_uart_n;

   localparam int unsigned CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   // instance A
   logic [3:0] save_n_a;
   logic [2:0] data_a;
   logic       clear_a, en_a, txd_a, busy_a;
   logic [4:0] sum_a;
   // instance B
   logic [3:0] save_n_b;
   logic [7:0] data_b;
   logic       clear_b, en_b, txd_b, busy_b;
   logic [9:0] sum_b;

   int n_tests = 0;
   int n_fail  = 0;
   int model_a [4];
   int exp_a [$];
   int exp_b [$];

   always #5 clk = ~clk;

   sum_latch_uart_n #(.DATA_W(3), .NUM_OPS(4), .CLKS_PER_BIT(CPB)) dut_a (
      .clk(clk), .reset(reset), .save_n(save_n_a), .data_input(data_a),
      .clear(clear_a), .uart_tx_en(en_a), .uart_txd(txd_a),
      .uart_tx_busy(busy_a), .sum_out(sum_a));

   sum_latch_uart_n #(.DATA_W(8), .NUM_OPS(4), .CLKS_PER_BIT(CPB)) dut_b (
      .clk(clk), .reset(reset), .save_n(save_n_b), .data_input(data_b),
      .clear(clear_b), .uart_tx_en(en_b), .uart_txd(txd_b),
      .uart_tx_busy(busy_b), .sum_out(sum_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%0h, no such event expected", name, act);
   endtask

   function automatic logic txd_of(input bit sel);
      return sel ? txd_b : txd_a;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   function automatic int model_sum();
      int s = 0;
      for (int i = 0; i < 4; i++) s += model_a[i];
      return s;
   endfunction

   task automatic step(input int n, inout bit ab);
      repeat (n) begin
         @(negedge clk);
         if (reset) ab = 1'b1;
      end
   endtask

   // Decode one frame of nb bytes from the mid-bit samples, then score it
   task automatic mon_frame(input bit sel, input int nb);
      logic [31:0] val;
      logic [7:0]  by;
      bit          ab;
      val = '0;
      ab  = 1'b0;
      for (int b = 0; b < nb; b++) begin
         step((b == 0) ? CPB / 2 : CPB, ab);
         if (!ab) chk(sel ? "start_bit_b" : "start_bit_a", 32'(txd_of(sel)), 32'd0);
         for (int i = 0; i < 8; i++) begin
            step(CPB, ab);
            by[i] = txd_of(sel);
         end
         step(CPB, ab);
         if (!ab) chk(sel ? "stop_bit_b" : "stop_bit_a", 32'(txd_of(sel)), 32'd1);
         val = val | (32'(by) << (8 * b));
      end
      if (!ab) begin
         if (sel) begin
            if (exp_b.size() == 0) fail("frame_b_unexpected", val);
            else chk("frame_b", val, 32'(exp_b.pop_front()));
         end else begin
            if (exp_a.size() == 0) fail("frame_a_unexpected", val);
            else chk("frame_a", val, 32'(exp_a.pop_front()));
         end
      end
   endtask

   // Busy must stay high for exactly one whole frame (unless reset cuts it)
   task automatic busy_mon(input bit sel, input int exp_len);
      forever begin
         @(negedge clk);
         if (busy_of(sel) === 1'b1 && !reset) begin
            int len;
            bit ab;
            len = 0;
            ab  = 1'b0;
            while (busy_of(sel) === 1'b1) begin
               len++;
               @(negedge clk);
               if (reset) ab = 1'b1;
            end
            if (!ab) chk(sel ? "busy_len_b" : "busy_len_a", 32'(len), 32'(exp_len));
         end
      end
   endtask

   initial begin : mon_a
      forever begin
         @(negedge clk);
         if (!reset && txd_a === 1'b0) mon_frame(1'b0, 1);
      end
   end

   initial begin : mon_b
      forever begin
         @(negedge clk);
         if (!reset && txd_b === 1'b0) mon_frame(1'b1, 2);
      end
   end

   initial busy_mon(1'b0, 10 * CPB);
   initial busy_mon(1'b1, 20 * CPB);

   // Save on instance A and check sum latency (old value at k+3, new at k+4)
   task automatic save_a(input logic [3:0] mask, input logic [2:0] d);
      int old_s, new_s;
      old_s = model_sum();
      for (int i = 0; i < 4; i++) if (mask[i]) model_a[i] = int'(d);
      new_s = model_sum();
      @(negedge clk);
      save_n_a = ~mask;
      data_a   = d;
      @(negedge clk);
      @(negedge clk);
      save_n_a = '1;
      @(negedge clk);
      @(negedge clk);
      chk("sum_a_before_update", 32'(sum_a), 32'(old_s));
      @(negedge clk);
      chk("sum_a", 32'(sum_a), 32'(new_s));
   endtask

   task automatic clear_ops_a();
      @(negedge clk);
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      for (int i = 0; i < 4; i++) model_a[i] = 0;
      @(negedge clk);
      chk("sum_a_after_clear", 32'(sum_a), 32'd0);
   endtask

   task automatic wait_drain(input bit sel);
      int t = 0;
      while (((sel ? exp_b.size() : exp_a.size()) != 0 || busy_of(sel) !== 1'b0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) fail(sel ? "drain_timeout_b" : "drain_timeout_a", 32'(t));
   endtask

   task automatic wait_busy(input logic level, input string name);
      int t = 0;
      while (busy_a !== level && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) fail(name, 32'(t));
   endtask

   initial begin : main
      int         g, seen;
      logic [3:0] mask;
      logic [2:0] d;
      reset    = 1'b1;
      save_n_a = '1; data_a = '0; clear_a = 1'b0; en_a = 1'b0;
      save_n_b = '1; data_b = '0; clear_b = 1'b0; en_b = 1'b0;
      for (int i = 0; i < 4; i++) model_a[i] = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_txd_a",  32'(txd_a),  32'd1);
      chk("reset_busy_a", 32'(busy_a), 32'd0);
      chk("reset_sum_a",  32'(sum_a),  32'd0);
      chk("reset_txd_b",  32'(txd_b),  32'd1);
      chk("reset_busy_b", 32'(busy_b), 32'd0);
      chk("reset_sum_b",  32'(sum_b),  32'd0);

      // wide instance: 4 x 255 = 0x3FC -> two back-to-back bytes
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         save_n_b = ~(4'b0001 << i);
         data_b   = 8'hFF;
         repeat (2) @(negedge clk);
         save_n_b = '1;
         repeat (3) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("sum_b", 32'(sum_b), 32'd1020);
      exp_b.push_back(1020);
      en_b = 1'b1;
      wait_drain(1'b1);
      repeat (20) @(negedge clk);
      en_b = 1'b0;

      // four operands with transmit disabled: line must stay idle
      save_a(4'b0001, 3'd3);
      save_a(4'b0010, 3'd5);
      save_a(4'b0100, 3'd7);
      save_a(4'b1000, 3'd6);
      repeat (20) @(negedge clk);
      chk("txd_idle_while_disabled", 32'(txd_a), 32'd1);

      // enable: frame 0x15; mid-frame save of op1=1 queues a 0x11 frame
      exp_a.push_back(21);
      en_a = 1'b1;
      wait_busy(1'b1, "busy_rise_timeout");
      repeat (10) @(negedge clk);
      save_a(4'b0010, 3'd1);
      exp_a.push_back(model_sum());
      wait_busy(1'b0, "busy_fall_timeout");
      g = 0;
      while (busy_a !== 1'b1 && g < 100) begin
         g++;
         @(negedge clk);
      end
      chk("idle_gap_between_frames", 32'(g), 32'd1);
      wait_drain(1'b0);
      repeat (60) @(negedge clk);
      chk("busy_stays_low_without_save", 32'(busy_a), 32'd0);
      en_a = 1'b0;

      // simultaneous strobes, then clear landing on the same edge as a save
      save_a(4'b0101, 3'd4);
      save_a(4'b1000, 3'd5);
      for (int i = 0; i < 4; i++) model_a[i] = 0;
      @(negedge clk);
      save_n_a = 4'b1100;
      data_a   = 3'd7;
      @(negedge clk);
      @(negedge clk);
      save_n_a = '1;
      @(negedge clk);
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      @(negedge clk);
      chk("clear_overrides_save", 32'(sum_a), 32'd0);
      exp_a.push_back(0);
      en_a = 1'b1;
      wait_drain(1'b0);
      en_a = 1'b0;

      // randomised rounds against the operand model
      repeat (10) begin
         repeat ($urandom_range(1, 3)) begin
            mask = 4'($urandom_range(1, 15));
            d    = 3'($urandom_range(0, 7));
            save_a(mask, d);
         end
         if ($urandom_range(0, 3) == 0) clear_ops_a();
         exp_a.push_back(model_sum());
         en_a = 1'b1;
         wait_drain(1'b0);
         en_a = 1'b0;
      end

      // reset in cycle 10 of a frame aborts it; nothing resends afterwards
      save_a(4'b0001, 3'd2);
      en_a = 1'b1;
      wait_busy(1'b1, "busy_rise_timeout_reset");
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midframe_reset_txd",  32'(txd_a),  32'd1);
      chk("midframe_reset_busy", 32'(busy_a), 32'd0);
      chk("midframe_reset_sum",  32'(sum_a),  32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) model_a[i] = 0;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy_a !== 1'b0) seen = 1;
      end
      chk("no_frame_after_reset", 32'(seen), 32'd0);
      en_a = 1'b0;

      chk("pending_frames_a", 32'(exp_a.size()), 32'd0);
      chk("pending_frames_b", 32'(exp_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
